// File: rtl/rec_play_sequencer.sv
// Record/playback sequencer for the guitar note RAM.
// Steps record and play one note per beat; owns RAM address and write enable.
module rec_play_sequencer #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              select,
  input  logic              back,
  input  logic              mode,
  input  logic              loop,
  input  logic              beat_tick,
  input  logic [DATA_W-1:0] note_in,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic [DATA_W-1:0] note_out,
  output logic              note_valid,
  output logic [ADDR_W:0]   take_len,
  output logic [3:0]        state
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_ARMED  = 4'd1,
    S_RECORD = 4'd2,
    S_DONE   = 4'd3,
    S_PLAY   = 4'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [DATA_W-1:0] note_q, note_d;
  logic              valid_q, valid_d;
  logic              pend_q, pend_d;
  logic              sel_q, bk_q;
  logic              sel_p, bk_p;
  logic [ADDR_W:0]   ptr_nxt;

  assign sel_p   = select & ~sel_q;
  assign bk_p    = back & ~bk_q;
  assign ptr_nxt = {1'b0, ptr_q} + (ADDR_W+1)'(1);

  assign ram_address = ptr_q;
  assign ram_data    = note_in;
  assign ram_wren    = (state_q == S_RECORD) & beat_tick;
  assign note_out    = note_q;
  assign note_valid  = valid_q;
  assign take_len    = len_q;
  assign state       = state_q;

  // State, pointer, take length, playback output and button history
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      len_q   <= '0;
      note_q  <= '0;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
      sel_q   <= 1'b0;
      bk_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      note_q  <= note_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
      sel_q   <= select;
      bk_q    <= back;
    end
  end

  // Next-state, pointer stepping and read pipeline
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    note_d  = note_q;
    valid_d = 1'b0;
    pend_d  = 1'b0;
    if (pend_q) begin
      note_d  = ram_q;
      valid_d = 1'b1;
    end
    unique case (state_q)
      S_IDLE: begin
        if (sel_p) begin
          if (mode) begin
            state_d = S_ARMED;
          end else if (len_q != '0) begin
            state_d = S_PLAY;
            ptr_d   = '0;
          end
        end
      end
      S_ARMED: begin
        if (bk_p) begin
          state_d = S_IDLE;
        end else if (sel_p) begin
          state_d = S_RECORD;
          ptr_d   = '0;
          len_d   = '0;
        end
      end
      S_RECORD: begin
        if (beat_tick) begin
          ptr_d = ptr_nxt[ADDR_W-1:0];
          len_d = len_q + (ADDR_W+1)'(1);
          if (ptr_q == ADDR_W'(DEPTH - 1)) begin
            state_d = S_DONE;
          end
        end
        if (sel_p | bk_p) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (sel_p | bk_p) begin
          state_d = S_IDLE;
        end
      end
      S_PLAY: begin
        if (sel_p | bk_p) begin
          state_d = S_IDLE;
          note_d  = note_q;
          valid_d = 1'b0;
        end else if (beat_tick) begin
          pend_d = 1'b1;
          if (ptr_nxt == len_q) begin
            ptr_d = '0;
            if (!loop) begin
              state_d = S_IDLE;
            end
          end else begin
            ptr_d = ptr_nxt[ADDR_W-1:0];
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rec_play_sequencer.sv
// Directed bench for rec_play_sequencer with a RAM model
// and scoreboards for RAM writes and playback notes.
module tb_rec_play_sequencer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        select, back, mode, loop, beat_tick;
  logic [31:0] note_in, ram_q, ram_data, note_out;
  logic [5:0]  ram_address;
  logic        ram_wren, note_valid;
  logic [6:0]  take_len;
  logic [3:0]  state;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [5:0]  a;
    logic [31:0] d;
  } wexp_t;

  typedef struct {
    logic [31:0] n;
    int          due;
  } nexp_t;

  wexp_t wq[$];
  nexp_t nq[$];
  logic [31:0] mem [64];

  rec_play_sequencer dut (
    .clk(clk), .resetn(resetn),
    .select(select), .back(back),
    .mode(mode), .loop(loop),
    .beat_tick(beat_tick), .note_in(note_in),
    .ram_q(ram_q), .ram_address(ram_address),
    .ram_data(ram_data), .ram_wren(ram_wren),
    .note_out(note_out), .note_valid(note_valid),
    .take_len(take_len), .state(state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // write scoreboard
  always @(negedge clk) begin
    if (resetn && ram_wren) begin
      if (wq.size() == 0) begin
        chk("unexpected_write", 32'(ram_address), 32'hFFFF_FFFF);
      end else begin
        wexp_t e;
        e = wq.pop_front();
        chk("wr_addr", 32'(ram_address), 32'(e.a));
        chk("wr_data", ram_data, e.d);
      end
    end
  end

  // playback note scoreboard, including timing
  always @(negedge clk) begin
    if (resetn) begin
      if (note_valid) begin
        if (nq.size() == 0) begin
          chk("unexpected_note", note_out, 32'hFFFF_FFFF);
        end else begin
          nexp_t e;
          e = nq.pop_front();
          chk("note_out", note_out, e.n);
          chk("note_cycle", 32'(cyc), 32'(e.due));
        end
      end else if (nq.size() != 0 && nq[0].due < cyc) begin
        nexp_t e;
        e = nq.pop_front();
        chk("missing_note", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_sel();
    select = 1'b1;
    step();
    select = 1'b0;
    step();
  endtask

  task automatic press_back();
    back = 1'b1;
    step();
    back = 1'b0;
    step();
  endtask

  task automatic rec_tick(logic [5:0] a, logic [31:0] d);
    wexp_t e;
    e.a = a;
    e.d = d;
    wq.push_back(e);
    note_in   = d;
    beat_tick = 1'b1;
    step();
    beat_tick = 1'b0;
    step();
  endtask

  task automatic play_tick(bit expect_note, logic [31:0] n);
    if (expect_note) begin
      nexp_t e;
      e.n   = n;
      e.due = cyc + 2;
      nq.push_back(e);
    end
    beat_tick = 1'b1;
    step();
    beat_tick = 1'b0;
    step(3);
  endtask

  logic [31:0] take3 [3];

  initial begin
    take3[0] = 32'h1;
    take3[1] = 32'h40;
    take3[2] = 32'h2000;
    resetn = 1'b0;
    select = 1'b0;
    back = 1'b0;
    mode = 1'b0;
    loop = 1'b0;
    beat_tick = 1'b0;
    note_in = '0;
    step(2);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_len", 32'(take_len), 32'd0);
    chk("rst_addr", 32'(ram_address), 32'd0);
    chk("rst_valid", 32'(note_valid), 32'd0);
    chk("rst_note", note_out, 32'd0);
    resetn = 1'b1;
    step(2);

    // play with empty take stays idle
    press_sel();
    chk("play_empty", 32'(state), 32'd0);

    // held select gives exactly one transition
    mode = 1'b1;
    select = 1'b1;
    step(100);
    select = 1'b0;
    step();
    chk("held_select", 32'(state), 32'd1);

    // record 5 notes then async reset mid-cycle
    press_sel();
    chk("rec_enter", 32'(state), 32'd2);
    for (int i = 0; i < 5; i++) rec_tick(6'(i), 32'h100 + 32'(i));
    chk("rec5_len", 32'(take_len), 32'd5);
    #2 resetn = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_len", 32'(take_len), 32'd0);
    chk("arst_addr", 32'(ram_address), 32'd0);
    chk("arst_valid", 32'(note_valid), 32'd0);
    step();
    resetn = 1'b1;
    step();

    // record the 3-note take
    press_sel();
    press_sel();
    for (int i = 0; i < 3; i++) rec_tick(6'(i), take3[i]);
    press_sel();
    chk("take3_len", 32'(take_len), 32'd3);
    chk("take3_done", 32'(state), 32'd3);
    press_sel();
    chk("done_idle", 32'(state), 32'd0);

    // arm then back keeps old take
    press_sel();
    chk("armed", 32'(state), 32'd1);
    press_back();
    chk("back_state", 32'(state), 32'd0);
    chk("back_len", 32'(take_len), 32'd3);

    // play once, loop off
    mode = 1'b0;
    press_sel();
    chk("play_enter", 32'(state), 32'd4);
    for (int i = 0; i < 3; i++) play_tick(1'b1, take3[i]);
    chk("play_end", 32'(state), 32'd0);
    play_tick(1'b0, '0);
    chk("play_q_empty", 32'(nq.size()), 32'd0);

    // looped play
    loop = 1'b1;
    press_sel();
    for (int i = 0; i < 7; i++) play_tick(1'b1, take3[i % 3]);
    chk("loop_state", 32'(state), 32'd4);
    press_back();
    chk("loop_abort", 32'(state), 32'd0);

    // back coinciding with a play tick drops the read
    press_sel();
    back = 1'b1;
    beat_tick = 1'b1;
    step();
    back = 1'b0;
    beat_tick = 1'b0;
    step(4);
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_hold", note_out, 32'h1);
    loop = 1'b0;

    // full-depth record
    mode = 1'b1;
    press_sel();
    press_sel();
    for (int i = 0; i < 64; i++)
      rec_tick(6'(i), $urandom() | 32'h1);
    chk("full_len", 32'(take_len), 32'd64);
    chk("full_state", 32'(state), 32'd3);
    beat_tick = 1'b1;
    #1;
    chk("tick65_wren", 32'(ram_wren), 32'd0);
    step();
    beat_tick = 1'b0;
    step(2);
    chk("wq_empty", 32'(wq.size()), 32'd0);
    chk("nq_empty", 32'(nq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
